// File: rtl/int_ctrl_if.sv
// Pipeline-facing bundle of the trap/interrupt controller: EX-stage trap sources,
// CSR window and the trap request outputs consumed by the next-PC stage.
interface int_ctrl_if;
    logic        PCWrite;
    logic        illegal_ex;
    logic        ecall_ex;
    logic        int_ret;
    logic        csr_we;
    logic [1:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        INT_Signal;
    logic [2:0]  INT_PEND;
    logic        EXL_Set;
    logic        flush;

    modport master (
        output PCWrite, illegal_ex, ecall_ex, int_ret, csr_we, csr_addr, csr_wdata,
        input  csr_rdata, INT_Signal, INT_PEND, EXL_Set, flush
    );

    modport slave (
        input  PCWrite, illegal_ex, ecall_ex, int_ret, csr_we, csr_addr, csr_wdata,
        output csr_rdata, INT_Signal, INT_PEND, EXL_Set, flush
    );
endinterface

// File: rtl/int_ctrl.sv
// Trap/interrupt controller: merges EX-stage exceptions with a periodic timer,
// tracks the exception level and exposes a CTRL/PERIOD/COUNT/STATUS CSR window.
module int_ctrl #(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] PERIOD_RST = {CNT_W{1'b0}}
) (
    input  logic       clk,
    input  logic       rst,
    int_ctrl_if.slave  bus
);
    logic [1:0]       ctrl_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] count_r;
    logic             tmr_pend_r;
    logic             exl_r;
    logic [2:0]       cause_r;
    logic             dbl_fault_r;

    logic             req_tmr_s;
    logic             int_sig_s;
    logic [2:0]       winner_s;
    logic             take_s;
    logic             timer_run_s;
    logic             wrap_s;
    logic             ctrl_we_s;
    logic             period_we_s;
    logic [31:0]      rdata_s;

    // Trap arbitration (illegal > ecall > timer) and timer wrap detection.
    always_comb begin
        req_tmr_s   = tmr_pend_r & ctrl_r[0];
        int_sig_s   = ~exl_r & (bus.illegal_ex | bus.ecall_ex | req_tmr_s);
        winner_s    = 3'd0;
        if (!int_sig_s) begin
            winner_s = 3'd0;
        end else if (bus.illegal_ex) begin
            winner_s = 3'd2;
        end else if (bus.ecall_ex) begin
            winner_s = 3'd3;
        end else begin
            winner_s = 3'd1;
        end
        take_s      = int_sig_s & bus.PCWrite;
        timer_run_s = ctrl_r[1] & (period_r != {CNT_W{1'b0}});
        wrap_s      = timer_run_s & (count_r == (period_r - CNT_W'(1'b1)));
        ctrl_we_s   = bus.csr_we & (bus.csr_addr == 2'd0);
        period_we_s = bus.csr_we & (bus.csr_addr == 2'd1);
    end

    // CSR read mux; STATUS packs EXL, pending timer, last cause and double fault.
    always_comb begin
        rdata_s = 32'd0;
        case (bus.csr_addr)
            2'd0:    rdata_s = {30'd0, ctrl_r};
            2'd1:    rdata_s = 32'(period_r);
            2'd2:    rdata_s = 32'(count_r);
            2'd3:    rdata_s = {26'd0, dbl_fault_r, cause_r, tmr_pend_r, exl_r};
            default: rdata_s = 32'd0;
        endcase
    end

    assign bus.csr_rdata  = rdata_s;
    assign bus.INT_Signal = int_sig_s;
    assign bus.INT_PEND   = winner_s;
    assign bus.EXL_Set    = exl_r;
    assign bus.flush      = take_s;

    // Controller state: CSRs, timer, exception level and fault bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r      <= 2'd0;
            period_r    <= PERIOD_RST;
            count_r     <= {CNT_W{1'b0}};
            tmr_pend_r  <= 1'b0;
            exl_r       <= 1'b0;
            cause_r     <= 3'd0;
            dbl_fault_r <= 1'b0;
        end else begin
            if (ctrl_we_s) begin
                ctrl_r <= bus.csr_wdata[1:0];
            end
            // A PERIOD write restarts the count regardless of where the timer was.
            if (period_we_s) begin
                period_r <= CNT_W'(bus.csr_wdata);
                count_r  <= {CNT_W{1'b0}};
            end else if (wrap_s) begin
                count_r  <= {CNT_W{1'b0}};
            end else if (timer_run_s) begin
                count_r  <= count_r + CNT_W'(1'b1);
            end
            // A wrap on the same edge as a timer take re-arms the pend.
            if (wrap_s) begin
                tmr_pend_r <= 1'b1;
            end else if (take_s && (winner_s == 3'd1)) begin
                tmr_pend_r <= 1'b0;
            end
            if (take_s) begin
                exl_r   <= 1'b1;
                cause_r <= winner_s;
            end else if (bus.int_ret && exl_r && bus.PCWrite) begin
                exl_r   <= 1'b0;
            end
            if (exl_r && bus.PCWrite && (bus.illegal_ex || bus.ecall_ex)) begin
                dbl_fault_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: a behavioural model predicts every cycle's
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_int_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_ctrl_if bus();

    int_ctrl #(.CNT_W(32), .PERIOD_RST(32'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic        sig;
        logic [2:0]  pend;
        logic        exl;
        logic        fl;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference state, as described architecturally.
    bit     m_exl, m_ie, m_te, m_pend, m_dbl;
    int     m_cause;
    longint m_period, m_count;

    task automatic model_reset();
        m_exl = 0; m_ie = 0; m_te = 0; m_pend = 0; m_dbl = 0;
        m_cause = 0; m_period = 0; m_count = 0;
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
        end
    endtask

    // Drive one cycle, predict its outputs, then advance the model past the edge.
    task automatic step(input bit r, input bit pcw, input bit ill, input bit ec, input bit ret,
                        input bit we, input logic [1:0] addr, input logic [31:0] wd);
        exp_t   e;
        bit     req_tmr, sig, wrap, take;
        int     winner;
        longint rd;
        rst = r;
        bus.PCWrite = pcw; bus.illegal_ex = ill; bus.ecall_ex = ec; bus.int_ret = ret;
        bus.csr_we = we; bus.csr_addr = addr; bus.csr_wdata = wd;

        req_tmr = m_pend && m_ie;
        sig     = !m_exl && (ill || ec || req_tmr);
        winner  = !sig ? 0 : ill ? 2 : ec ? 3 : 1;
        take    = sig && pcw;
        case (addr)
            2'd0:    rd = m_ie + 2 * m_te;
            2'd1:    rd = m_period;
            2'd2:    rd = m_count;
            default: rd = m_exl + 2 * m_pend + 4 * m_cause + 32 * m_dbl;
        endcase
        e.cyc = cyc; e.sig = sig; e.pend = 3'(winner); e.exl = m_exl; e.fl = take; e.rd = 32'(rd);
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            wrap = m_te && m_period != 0 && m_count == m_period - 1;
            if (we && addr == 2'd1) m_count = 0;
            else if (m_te && m_period != 0) m_count = (m_count + 1) % m_period;
            if (we && addr == 2'd1) m_period = longint'(wd);
            if (we && addr == 2'd0) begin m_ie = wd[0]; m_te = wd[1]; end
            if (wrap) m_pend = 1;
            else if (take && winner == 1) m_pend = 0;
            if (m_exl && pcw && (ill || ec)) m_dbl = 1;
            if (take) begin m_exl = 1; m_cause = winner; end
            else if (ret && m_exl && pcw) m_exl = 0;
        end
    endtask

    task automatic idle(input int n, input bit pcw, input logic [1:0] addr);
        for (int i = 0; i < n; i++) step(0, pcw, 0, 0, 0, 0, addr, 32'd0);
    endtask

    // Monitor: every cycle the DUT presents its outputs; compare with the oldest prediction.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("INT_Signal", e.cyc, 32'(bus.INT_Signal), 32'(e.sig));
            chk("INT_PEND",   e.cyc, 32'(bus.INT_PEND),   32'(e.pend));
            chk("EXL_Set",    e.cyc, 32'(bus.EXL_Set),    32'(e.exl));
            chk("flush",      e.cyc, 32'(bus.flush),      32'(e.fl));
            chk("csr_rdata",  e.cyc, bus.csr_rdata,       e.rd);
        end
    end

    initial begin
        rst = 1'b1;
        bus.PCWrite = 1'b0; bus.illegal_ex = 1'b0; bus.ecall_ex = 1'b0; bus.int_ret = 1'b0;
        bus.csr_we = 1'b0; bus.csr_addr = 2'd0; bus.csr_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, then timer trap with PERIOD=5.
        step(1, 0, 0, 0, 0, 0, 2'd3, 32'd0);
        step(0, 0, 0, 0, 0, 1, 2'd0, 32'd3);
        step(0, 0, 0, 0, 0, 1, 2'd1, 32'd5);
        idle(6, 0, 2'd2);
        idle(1, 1, 2'd3);
        idle(7, 1, 2'd2);
        // Return, let the timer pend re-arm, then illegal+ecall+timer together.
        step(0, 1, 0, 0, 1, 0, 2'd3, 32'd0);
        idle(5, 0, 2'd3);
        step(0, 0, 1, 1, 0, 0, 2'd3, 32'd0);
        step(0, 1, 1, 1, 0, 0, 2'd3, 32'd0);
        idle(1, 0, 2'd3);
        // Double fault inside the handler, then return and timer trap.
        step(0, 1, 0, 1, 0, 0, 2'd3, 32'd0);
        step(0, 1, 0, 0, 1, 0, 2'd3, 32'd0);
        idle(3, 1, 2'd3);
        // Stall: request held with PCWrite=0, then taken.
        step(0, 1, 0, 0, 1, 0, 2'd3, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 2'd3, 32'd0);
        step(0, 1, 0, 1, 0, 0, 2'd3, 32'd0);
        // PERIOD=4 so a wrap meets a timer take; then PERIOD rewrite mid-count.
        step(0, 1, 0, 0, 1, 1, 2'd1, 32'd4);
        idle(12, 0, 2'd2);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1, 0, 2'(i), 32'd0);
        step(0, 0, 0, 0, 0, 1, 2'd1, 32'd10);
        idle(2, 0, 2'd2);
        // Reset mid-trap.
        step(0, 1, 1, 0, 0, 0, 2'd3, 32'd0);
        step(1, 0, 0, 0, 0, 0, 2'd2, 32'd0);
        idle(1, 0, 2'd3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r, pcw, ill, ec, ret, we;
            logic [1:0]  addr;
            logic [31:0] wd;
            r    = ($urandom_range(0, 299) == 0);
            pcw  = ($urandom_range(0, 9) < 7);
            ill  = ($urandom_range(0, 11) == 0);
            ec   = ($urandom_range(0, 11) == 0);
            ret  = ($urandom_range(0, 4) == 0);
            we   = ($urandom_range(0, 9) == 0);
            addr = 2'($urandom_range(0, 3));
            wd   = (addr == 2'd1) ? 32'($urandom_range(0, 9)) : 32'($urandom);
            step(r, pcw, ill, ec, ret, we, addr, wd);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
